fp_exp_ternary_stage: RTL and testbench

- Upstream operand stage for the 8-bit ternary exponent adder (x+y+z+cin, 8-bit wrapped sum, no carry-out) in the FPApprox approximate mul/div datapath.
- Registers exponent pairs under a valid/ready handshake and forms the x/y/z/cin operands so the adder computes a+b-BIAS (mul) or a-b+BIAS (div).
- Captures the adder sum one stage later, adds overflow/underflow flags and optional saturation, and cross-checks the sum against a wide shadow result.

---
 rtl/fp_approx_pkg.sv | 21 ++
 rtl/fp_exp_operand_map.sv | 40 ++++
 rtl/fp_exp_ternary_stage.sv | 111 +++++++++++
 tb/tb_fp_exp_ternary_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_approx_pkg.sv
// Shared constants and types for the FPApprox exponent datapath.
// Operand bundle carried from the mapper into stage 1.
package fp_approx_pkg;
    localparam int EXP_W    = 8;
    localparam int EXP_BIAS = 127;
    localparam int SHADOW_W = 10;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [EXP_W-1:0] MUL_Z = 8'h81;
    localparam logic [EXP_W-1:0] DIV_Z = 8'h7F;

    typedef struct packed {
        logic [EXP_W-1:0]           x;
        logic [EXP_W-1:0]           y;
        logic [EXP_W-1:0]           z;
        logic                       cin;
        logic signed [SHADOW_W-1:0] shadow;
    } operand_t;
endpackage

// File: rtl/fp_exp_operand_map.sv
// Maps op/a/b onto ternary-adder operands plus the exact signed shadow.
// mul: a+b+(256-BIAS); div: a+~b+BIAS+1 == a-b+BIAS (mod 256).
import fp_approx_pkg::*;

module fp_exp_operand_map #(
    parameter int BIAS = EXP_BIAS
) (
    input  logic             op,
    input  logic [EXP_W-1:0] a,
    input  logic [EXP_W-1:0] b,
    output operand_t         opnd
);
    localparam logic signed [SHADOW_W-1:0] BIAS_S = SHADOW_W'(BIAS);

    logic signed [SHADOW_W-1:0] a_s;
    logic signed [SHADOW_W-1:0] b_s;

    assign a_s = signed'({2'b00, a});
    assign b_s = signed'({2'b00, b});

    always_comb begin
        opnd = '0;
        unique case (1'b1)
            (op == OP_DIV): begin
                opnd.x      = a;
                opnd.y      = ~b;
                opnd.z      = EXP_W'(BIAS);
                opnd.cin    = 1'b1;
                opnd.shadow = a_s - b_s + BIAS_S;
            end
            (op == OP_MUL): begin
                opnd.x      = a;
                opnd.y      = b;
                opnd.z      = EXP_W'(256 - BIAS);
                opnd.cin    = 1'b0;
                opnd.shadow = a_s + b_s - BIAS_S;
            end
        endcase
    end
endmodule

// File: rtl/fp_exp_ternary_stage.sv
// Two-register operand/result stage around an external ternary exponent adder.
// Stage 1 drives the adder; stage 2 flags, saturates and cross-checks its sum.
import fp_approx_pkg::*;

module fp_exp_ternary_stage #(
    parameter int TAG_W    = 4,
    parameter int BIAS     = 127,
    parameter int SATURATE = 1,
    parameter int CHECK    = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [EXP_W-1:0] in_exp_a,
    input  logic [EXP_W-1:0] in_exp_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [EXP_W-1:0] add_x,
    output logic [EXP_W-1:0] add_y,
    output logic [EXP_W-1:0] add_z,
    output logic             add_cin,
    input  logic [EXP_W-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_ovf,
    output logic             out_unf,
    output logic [TAG_W-1:0] out_tag,
    output logic             chk_err
);
    localparam logic signed [SHADOW_W-1:0] SAT_HI = 10'sd255;
    localparam logic signed [SHADOW_W-1:0] SAT_LO = 10'sd0;

    operand_t                   opnd_d;
    operand_t                   s1_q;
    logic                       s1_valid;
    logic [TAG_W-1:0]           s1_tag;
    logic signed [SHADOW_W-1:0] shadow_q;
    logic                       adv;
    logic                       acc;
    logic                       mv;
    logic                       ovf_d;
    logic                       unf_d;
    logic [EXP_W-1:0]           exp_d;

    fp_exp_operand_map #(
        .BIAS (BIAS)
    ) u_map (
        .op   (in_op),
        .a    (in_exp_a),
        .b    (in_exp_b),
        .opnd (opnd_d)
    );

    assign adv      = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv;
    assign acc      = in_valid && in_ready;
    assign mv       = s1_valid && adv;

    assign add_x    = s1_q.x;
    assign add_y    = s1_q.y;
    assign add_z    = s1_q.z;
    assign add_cin  = s1_q.cin;
    assign shadow_q = s1_q.shadow;

    assign ovf_d = shadow_q >= SAT_HI;
    assign unf_d = shadow_q <= SAT_LO;

    always_comb begin
        exp_d = add_sum;
        if (SATURATE != 0) begin
            if (ovf_d)
                exp_d = '1;
            else if (unf_d)
                exp_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_tag   <= '0;
            chk_err   <= 1'b0;
        end else begin
            // in_ready means stage 1 is empty or draining this cycle
            if (in_ready)
                s1_valid <= in_valid;
            if (acc) begin
                s1_q   <= opnd_d;
                s1_tag <= in_tag;
            end
            if (adv)
                out_valid <= s1_valid;
            if (mv) begin
                out_exp <= exp_d;
                out_ovf <= ovf_d;
                out_unf <= unf_d;
                out_tag <= s1_tag;
            end
            if ((CHECK != 0) && mv && (add_sum != shadow_q[EXP_W-1:0]))
                chk_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_exp_ternary_stage.sv
// Randomised and directed bench for fp_exp_ternary_stage.
// Second instance runs unsaturated to expose the raw wrapped sum.
module tb_fp_exp_ternary_stage;
    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic       in_op;
    logic [7:0] in_exp_a;
    logic [7:0] in_exp_b;
    logic [3:0] in_tag;
    logic [7:0] add_x, add_y, add_z;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_exp;
    logic       out_ovf, out_unf;
    logic [3:0] out_tag;
    logic       chk_err;
    logic       flip;

    logic       n_in_ready;
    logic [7:0] n_x, n_y, n_z;
    logic       n_cin;
    logic [7:0] n_sum;
    logic       n_out_valid;
    logic [7:0] n_out_exp;
    logic       n_ovf, n_unf;
    logic [3:0] n_tag;
    logic       n_chk_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] e;
        logic       ovf;
        logic       unf;
        logic [3:0] tag;
        logic [7:0] raw;
    } res_t;

    always #5 clk = ~clk;

    // Behavioural ternary adder in the parent, with a fault-injection flip
    assign add_sum = 8'(add_x + add_y + add_z + 8'(add_cin)) ^ {7'b0, flip};
    assign n_sum   = 8'(n_x + n_y + n_z + 8'(n_cin));

    fp_exp_ternary_stage #(.TAG_W(4), .BIAS(127), .SATURATE(1), .CHECK(1)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b), .in_tag(in_tag),
        .add_x(add_x), .add_y(add_y), .add_z(add_z), .add_cin(add_cin),
        .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_tag(out_tag),
        .chk_err(chk_err)
    );

    fp_exp_ternary_stage #(.TAG_W(4), .BIAS(127), .SATURATE(0), .CHECK(1)) dut_ns (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_op(in_op),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b), .in_tag(in_tag),
        .add_x(n_x), .add_y(n_y), .add_z(n_z), .add_cin(n_cin),
        .add_sum(n_sum),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_exp(n_out_exp),
        .out_ovf(n_ovf), .out_unf(n_unf), .out_tag(n_tag),
        .chk_err(n_chk_err)
    );

    function automatic res_t ref_model(bit op, int a, int b, logic [3:0] tag);
        res_t m;
        int   r;
        r     = op ? (a - b + 127) : (a + b - 127);
        m.ovf = (r >= 255);
        m.unf = (r <= 0);
        m.raw = 8'(r & 255);
        m.e   = m.ovf ? 8'hFF : (m.unf ? 8'h00 : m.raw);
        m.tag = tag;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flip      = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({out_valid, out_ovf, out_unf, chk_err, in_ready} !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 00001",
                     {out_valid, out_ovf, out_unf, chk_err, in_ready});
        end
        n_cmp++;
        if ({out_exp, out_tag} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_out got %h want 000", {out_exp, out_tag});
        end
        n_cmp++;
        if ({add_x, add_y, add_z, add_cin} !== 25'h0) begin
            n_bad++;
            $display("FAIL reset_opnd got %h want 0", {add_x, add_y, add_z, add_cin});
        end
    endtask

    task automatic test_single(string name, bit op, logic [7:0] a, logic [7:0] b);
        res_t        m;
        logic [3:0]  tg;
        logic [24:0] want_op;
        tg = 4'($urandom_range(0, 15));
        m  = ref_model(op, int'(a), int'(b), tg);
        want_op = {a, op ? ~b : b, op ? 8'h7F : 8'h81, op};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_exp_a  = a;
        in_exp_b  = b;
        in_tag    = tg;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({add_x, add_y, add_z, add_cin} !== want_op) begin
            n_bad++;
            $display("FAIL %s_opnd got %h want %h", name,
                     {add_x, add_y, add_z, add_cin}, want_op);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_early got out_valid=%b want 0", name, out_valid);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_exp, out_ovf, out_unf, out_tag, chk_err} !==
            {1'b1, m.e, m.ovf, m.unf, m.tag, 1'b0}) begin
            n_bad++;
            $display("FAIL %s_sat got v=%b e=%h o=%b u=%b t=%h c=%b want e=%h o=%b u=%b t=%h",
                     name, out_valid, out_exp, out_ovf, out_unf, out_tag, chk_err,
                     m.e, m.ovf, m.unf, m.tag);
        end
        n_cmp++;
        if ({n_out_valid, n_out_exp, n_ovf, n_unf} !== {1'b1, m.raw, m.ovf, m.unf}) begin
            n_bad++;
            $display("FAIL %s_raw got e=%h o=%b u=%b want e=%h o=%b u=%b",
                     name, n_out_exp, n_ovf, n_unf, m.raw, m.ovf, m.unf);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_dup got out_valid=%b want 0", name, out_valid);
        end
    endtask

    task automatic test_directed();
        test_single("mul_130_127", 1'b0, 8'd130, 8'd127);
        test_single("mul_200_200", 1'b0, 8'd200, 8'd200);
        test_single("div_10_200", 1'b1, 8'd10, 8'd200);
        test_single("div_127_127", 1'b1, 8'd127, 8'd127);
        test_single("mul_ovf_edge", 1'b0, 8'd255, 8'd127);
        test_single("mul_below_ovf", 1'b0, 8'd254, 8'd127);
        test_single("mul_unf_edge", 1'b0, 8'd127, 8'd0);
        test_single("mul_above_unf", 1'b0, 8'd128, 8'd0);
        test_single("div_max", 1'b1, 8'd255, 8'd0);
        test_single("div_min", 1'b1, 8'd0, 8'd255);
    endtask

    task automatic run_stream(string name, int n_ops, bit rnd);
        res_t       q[$];
        int         acc = 0;
        int         got = 0;
        int         cyc = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_exp = '0;
        logic [3:0] prev_tag = '0;
        logic       want_rdy;
        bit         op;
        int         a, b;
        while ((acc < n_ops || q.size() != 0) && cyc < 3000) begin
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_spurious tag=%h with nothing in flight", name, out_tag);
                end else if ({out_exp, out_ovf, out_unf, out_tag, n_out_exp} !==
                             {q[0].e, q[0].ovf, q[0].unf, q[0].tag, q[0].raw}) begin
                    n_bad++;
                    $display("FAIL %s_data got e=%h o=%b u=%b t=%h r=%h want e=%h o=%b u=%b t=%h r=%h",
                             name, out_exp, out_ovf, out_unf, out_tag, n_out_exp,
                             q[0].e, q[0].ovf, q[0].unf, q[0].tag, q[0].raw);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_exp !== prev_exp || out_tag !== prev_tag) begin
                    n_bad++;
                    $display("FAIL %s_hold got v=%b e=%h t=%h want v=1 e=%h t=%h",
                             name, out_valid, out_exp, out_tag, prev_exp, prev_tag);
                end
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 4) == 0 || (cyc % 4) == 3);
            in_valid  = (acc < n_ops) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            op        = 1'($urandom_range(0, 1));
            a         = int'($urandom_range(0, 255));
            b         = int'($urandom_range(0, 255));
            in_op     = op;
            in_exp_a  = 8'(a);
            in_exp_b  = 8'(b);
            in_tag    = 4'(acc);
            #1;
            want_rdy = !(q.size() == 2 && !out_ready);
            n_cmp++;
            if (in_ready !== want_rdy) begin
                n_bad++;
                $display("FAIL %s_in_ready got %b want %b (in flight %0d)",
                         name, in_ready, want_rdy, q.size());
            end
            prev_stall = out_valid && !out_ready;
            prev_exp   = out_exp;
            prev_tag   = out_tag;
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_model(op, a, b, 4'(acc)));
                acc++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (cyc >= 3000 || got != n_ops) begin
            n_bad++;
            $display("FAIL %s_count got %0d delivered in %0d cycles want %0d", name, got, cyc, n_ops);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || chk_err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_drain got v=%b chk=%b want 0 0", name, out_valid, chk_err);
        end
    endtask

    task automatic test_back_to_back();
        run_stream("b2b", 16, 1'b0);
    endtask

    task automatic test_random();
        run_stream("rand", 300, 1'b1);
    endtask

    task automatic test_check();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 1'b0;
        in_exp_a  = 8'd100;
        in_exp_b  = 8'd50;
        in_tag    = 4'h5;
        tick();
        in_valid = 1'b0;
        flip     = 1'b1;
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_bad++;
            $display("FAIL chk_early got %b want 0", chk_err);
        end
        tick();
        flip = 1'b0;
        n_cmp++;
        if ({chk_err, n_chk_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL chk_set got %b%b want 10", chk_err, n_chk_err);
        end
        in_valid = 1'b1;
        in_exp_a = 8'd140;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (chk_err !== 1'b1) begin
            n_bad++;
            $display("FAIL chk_sticky got %b want 1", chk_err);
        end
        do_reset();
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_bad++;
            $display("FAIL chk_clear got %b want 0", chk_err);
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 1'b0;
        in_exp_a  = 8'd130;
        in_exp_b  = 8'd127;
        in_tag    = 4'h1;
        tick();
        in_tag = 4'h2;
        tick();
        in_tag = 4'h3;
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b01) begin
            n_bad++;
            $display("FAIL full_stall got rdy=%b v=%b want 0 1", in_ready, out_valid);
        end
        resetn   = 1'b0;
        in_valid = 1'b0;
        tick();
        resetn = 1'b1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL midreset got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0)
                seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midreset_stale got %0d stale outputs want 0", seen);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_exp_a  = '0;
        in_exp_b  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        flip      = 1'b0;
        tick();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_check();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
